mesi_isc_tb_ins_gen: RTL and testbench

// Per-CPU stimulus generator for the MESI ISC bench. One instance drives the tb_ins_i/tb_ins_addr_i

---
 rtl/mesi_isc_tb_ins_gen_if.sv | 9 +
 rtl/mesi_isc_tb_ins_gen.sv | 204 ++++++++++++++++++++
 tb/tb_mesi_isc_tb_ins_gen.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mesi_isc_tb_ins_gen_if.sv
// Instruction/acknowledge handshake between one stimulus generator and one CPU model.
interface mesi_isc_tb_ins_gen_if;
  logic [3:0] tb_ins;
  logic [3:0] tb_ins_addr;
  logic       tb_ins_ack;

  modport master (output tb_ins, output tb_ins_addr, input tb_ins_ack);
  modport slave  (input tb_ins, input tb_ins_addr, output tb_ins_ack);
endinterface

// File: rtl/mesi_isc_tb_ins_gen.sv
// Seeded LFSR stimulus generator for one MESI ISC CPU model: issues NOP/WR/RD,
// handshakes on ack, counts completions, stops after NUM_INS and flags ack starvation.
module mesi_isc_tb_ins_gen #(
  parameter logic [15:0] SEED     = 16'h0001,
  parameter int unsigned NUM_INS  = 1000,
  parameter int unsigned ADDR_MAX = 9,
  parameter int unsigned TIMEOUT  = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  mesi_isc_tb_ins_gen_if.master ins_if,
  output logic                  done_o,
  output logic                  err_o,
  output logic [15:0]           ins_cnt_o,
  output logic [15:0]           wr_cnt_o,
  output logic [15:0]           rd_cnt_o
);

  localparam int unsigned CW = 16;
  localparam int unsigned IW = 4;
  localparam int unsigned AW = 4;

  localparam logic [IW-1:0] INS_NOP = IW'(0);
  localparam logic [IW-1:0] INS_WR  = IW'(1);
  localparam logic [IW-1:0] INS_RD  = IW'(2);

  localparam logic [CW-1:0] LFSR_TAPS = 16'hB400;
  localparam logic [CW-1:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [CW-1:0] NUM_INS_C = CW'(NUM_INS);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
  localparam logic [AW:0]   ADDR_MAX_C = (AW+1)'(ADDR_MAX);
  localparam logic [AW:0]   ADDR_MOD_C = (AW+1)'(ADDR_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_ISSUE,
    S_RELEASE,
    S_GAP,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] lfsr_q, lfsr_d;
  logic [IW-1:0] ins_q, ins_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    gcnt_q, gcnt_d;
  logic [CW-1:0] wdog_q, wdog_d;
  logic          err_q, err_d;
  logic          done_q, done_d;
  logic [CW-1:0] ins_cnt_q, ins_cnt_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;

  logic [CW-1:0] lfsr_nxt;
  logic [IW-1:0] op_nxt;
  logic [AW-1:0] addr_nxt;
  logic [AW:0]   a_raw;
  logic [3:0]    gap_nxt;
  logic [CW-1:0] ins_cnt_inc;
  logic [CW-1:0] wdog_inc;
  logic          ack;

  assign ack         = ins_if.tb_ins_ack;
  assign ins_cnt_inc = ins_cnt_q + CW'(1);
  assign wdog_inc    = wdog_q + CW'(1);

  // Galois right-shift step and decode of the value it produces
  always_comb begin
    lfsr_nxt = {1'b0, lfsr_q[CW-1:1]};
    if (lfsr_q[0]) lfsr_nxt = lfsr_nxt ^ LFSR_TAPS;
    a_raw   = {1'b0, lfsr_nxt[13:10]};
    gap_nxt = lfsr_nxt[3:0];
    unique case (lfsr_nxt[15:14])
      2'b00:   op_nxt = INS_NOP;
      2'b01:   op_nxt = INS_WR;
      default: op_nxt = INS_RD;
    endcase
    addr_nxt = (a_raw > ADDR_MAX_C) ? AW'(a_raw - ADDR_MOD_C) : a_raw[AW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      lfsr_q    <= SEED_EFF;
      ins_q     <= INS_NOP;
      addr_q    <= '0;
      gcnt_q    <= '0;
      wdog_q    <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      ins_cnt_q <= '0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      ins_q     <= ins_d;
      addr_q    <= addr_d;
      gcnt_q    <= gcnt_d;
      wdog_q    <= wdog_d;
      err_q     <= err_d;
      done_q    <= done_d;
      ins_cnt_q <= ins_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    ins_d     = ins_q;
    addr_d    = addr_q;
    gcnt_d    = gcnt_q;
    wdog_d    = wdog_q;
    err_d     = err_q;
    done_d    = done_q;
    ins_cnt_d = ins_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (en_i) state_d = S_GEN;
      end

      // The LFSR only moves here, so a parked generator resumes the same stream
      S_GEN: begin
        if (!en_i) begin
          state_d = S_IDLE;
        end else begin
          lfsr_d = lfsr_nxt;
          if (op_nxt != INS_NOP) begin
            ins_d   = op_nxt;
            addr_d  = addr_nxt;
            wdog_d  = '0;
            state_d = S_ISSUE;
          end else begin
            gcnt_d  = gap_nxt;
            state_d = S_GAP;
          end
        end
      end

      // Starvation is only reported; the op keeps waiting for its ack
      S_ISSUE: begin
        if (ack) begin
          ins_d     = INS_NOP;
          ins_cnt_d = ins_cnt_inc;
          if (ins_q == INS_WR) wr_cnt_d = wr_cnt_q + CW'(1);
          else                 rd_cnt_d = rd_cnt_q + CW'(1);
          wdog_d    = '0;
          state_d   = S_RELEASE;
        end else begin
          if (wdog_q != '1) wdog_d = wdog_inc;
          if (wdog_inc == TIMEOUT_C) err_d = 1'b1;
        end
      end

      S_RELEASE: begin
        if (!ack) begin
          if (ins_cnt_q == NUM_INS_C) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_GEN;
          end
        end
      end

      S_GAP: begin
        if (gcnt_q == 4'd0) begin
          ins_cnt_d = ins_cnt_inc;
          if (ins_cnt_inc == NUM_INS_C) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_GEN;
          end
        end else begin
          gcnt_d = gcnt_q - 4'd1;
        end
      end

      S_DONE: begin
        ins_d  = INS_NOP;
        done_d = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign ins_if.tb_ins      = ins_q;
  assign ins_if.tb_ins_addr = addr_q;
  assign done_o             = done_q;
  assign err_o              = err_q;
  assign ins_cnt_o          = ins_cnt_q;
  assign wr_cnt_o           = wr_cnt_q;
  assign rd_cnt_o           = rd_cnt_q;

endmodule

// File: tb/tb_mesi_isc_tb_ins_gen.sv
// Scoreboard bench for mesi_isc_tb_ins_gen: a reference LFSR model queues the expected
// op stream, a CPU-style responder acks it and each issued op is checked on arrival.
module tb_mesi_isc_tb_ins_gen;

  localparam int unsigned ADDR_MAX = 9;
  localparam int unsigned TIMEOUT  = 500;
  localparam logic [3:0]  NOP = 4'd0;
  localparam logic [3:0]  WR  = 4'd1;
  localparam logic [3:0]  RD  = 4'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, en_s;
  logic        done, err, done_s, err_s;
  logic [15:0] ins_cnt, wr_cnt, rd_cnt;
  logic [15:0] ins_cnt_s, wr_cnt_s, rd_cnt_s;

  int total = 0;
  int bad   = 0;

  mesi_isc_tb_ins_gen_if bus ();
  mesi_isc_tb_ins_gen_if bus_s ();

  always #5 clk = ~clk;

  mesi_isc_tb_ins_gen #(
    .SEED(16'h0001), .NUM_INS(20000), .ADDR_MAX(ADDR_MAX), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .en_i(en), .ins_if(bus),
    .done_o(done), .err_o(err),
    .ins_cnt_o(ins_cnt), .wr_cnt_o(wr_cnt), .rd_cnt_o(rd_cnt)
  );

  mesi_isc_tb_ins_gen #(
    .SEED(16'h0001), .NUM_INS(4), .ADDR_MAX(ADDR_MAX), .TIMEOUT(TIMEOUT)
  ) dut_small (
    .clk(clk), .rst(rst), .en_i(en_s), .ins_if(bus_s),
    .done_o(done_s), .err_o(err_s),
    .ins_cnt_o(ins_cnt_s), .wr_cnt_o(wr_cnt_s), .rd_cnt_o(rd_cnt_s)
  );

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  addr;
    int          zeros;
    logic [15:0] ins_b;
    logic [15:0] wr_b;
    logic [15:0] rd_b;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] m_lfsr, m_ins, m_wr, m_rd;
  bit          first, in_op, ack_r;
  int          zeros, issues;
  logic [15:0] seen;
  logic [3:0]  max_addr;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  // Walk the model to the next non-NOP op and queue what the DUT must show for it
  task automatic push_expected();
    exp_t e;
    int z;
    logic [3:0] a, g;
    z = 2;
    for (int k = 0; k < 1000; k++) begin
      m_lfsr = lfsr_step(m_lfsr);
      a = m_lfsr[13:10];
      g = m_lfsr[3:0];
      if (m_lfsr[15:14] == 2'b00) begin
        z += int'(g) + 2;
        m_ins++;
      end else begin
        e.op    = (m_lfsr[15:14] == 2'b01) ? WR : RD;
        e.addr  = (a > 4'(ADDR_MAX)) ? a - 4'(ADDR_MAX + 1) : a;
        e.zeros = z;
        e.ins_b = m_ins;
        e.wr_b  = m_wr;
        e.rd_b  = m_rd;
        exp_q.push_back(e);
        m_ins++;
        if (e.op == WR) m_wr++;
        else            m_rd++;
        break;
      end
    end
  endtask

  task automatic model_reset();
    m_lfsr = 16'h0001;
    m_ins  = '0;
    m_wr   = '0;
    m_rd   = '0;
    exp_q.delete();
    first  = 1'b1;
    in_op  = 1'b0;
    ack_r  = 1'b0;
    zeros  = 0;
    push_expected();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    en  = 1'b0;
    en_s = 1'b0;
    bus.tb_ins_ack   = 1'b0;
    bus_s.tb_ins_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One responder cycle on the main bus: check any newly issued op, then ack it
  task automatic auto_step();
    exp_t e;
    logic [3:0] cur;
    logic nack;
    @(negedge clk);
    cur = bus.tb_ins;
    if (cur != NOP && !in_op) begin
      in_op = 1'b1;
      issues++;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_empty: op %0d issued with nothing queued", cur);
      end else begin
        e = exp_q.pop_front();
        total++; if (cur !== e.op) begin bad++; $display("FAIL sb_op: got %0d want %0d", cur, e.op); end
        total++; if (bus.tb_ins_addr !== e.addr) begin bad++; $display("FAIL sb_addr: got %0d want %0d", bus.tb_ins_addr, e.addr); end
        total++; if (ins_cnt !== e.ins_b) begin bad++; $display("FAIL sb_ins_cnt: got %0d want %0d", ins_cnt, e.ins_b); end
        total++; if (wr_cnt !== e.wr_b) begin bad++; $display("FAIL sb_wr_cnt: got %0d want %0d", wr_cnt, e.wr_b); end
        total++; if (rd_cnt !== e.rd_b) begin bad++; $display("FAIL sb_rd_cnt: got %0d want %0d", rd_cnt, e.rd_b); end
        if (!first) begin
          total++; if (zeros !== e.zeros) begin bad++; $display("FAIL sb_gap_cycles: got %0d want %0d", zeros, e.zeros); end
        end
      end
      seen[bus.tb_ins_addr] = 1'b1;
      if (bus.tb_ins_addr > max_addr) max_addr = bus.tb_ins_addr;
      first = 1'b0;
      zeros = 0;
    end else if (cur == NOP) begin
      in_op = 1'b0;
      zeros++;
    end
    nack = (cur != NOP);
    if (ack_r && !nack) push_expected();
    ack_r = nack;
    bus.tb_ins_ack = nack;
  endtask

  task automatic run_auto(input int target, input int budget);
    int n;
    n = 0;
    while (int'(ins_cnt) < target && n < budget) begin
      auto_step();
      n++;
    end
    total++;
    if (int'(ins_cnt) < target) begin
      bad++; $display("FAIL run_budget: ins_cnt got %0d want %0d", ins_cnt, target);
    end
  endtask

  task automatic wait_issue(input string tag);
    int n;
    n = 0;
    while (bus.tb_ins == NOP && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus.tb_ins == NOP) begin bad++; $display("FAIL %s_no_issue: got NOP want op", tag); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b0; en_s = 1'b0;
    bus.tb_ins_ack = 1'b0; bus_s.tb_ins_ack = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.tb_ins, bus.tb_ins_addr, done, err, ins_cnt, wr_cnt, rd_cnt} !== '0) begin
      bad++; $display("FAIL reset_main: got ins=%0d addr=%0d done=%0b err=%0b cnt=%0d want all 0",
                      bus.tb_ins, bus.tb_ins_addr, done, err, ins_cnt);
    end
    total++;
    if ({bus_s.tb_ins, bus_s.tb_ins_addr, done_s, err_s, ins_cnt_s, wr_cnt_s, rd_cnt_s} !== '0) begin
      bad++; $display("FAIL reset_small: got ins=%0d done=%0b cnt=%0d want all 0", bus_s.tb_ins, done_s, ins_cnt_s);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (bus.tb_ins !== NOP || ins_cnt !== 16'd0) begin
      bad++; $display("FAIL idle_hold: got ins=%0d cnt=%0d want 0 0", bus.tb_ins, ins_cnt);
    end
  endtask

  // Latency from enable, the first three decoded instructions, and reset mid-ISSUE
  task automatic test_latency_first_ops();
    apply_reset();
    @(posedge clk);
    #1 en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (bus.tb_ins !== NOP) begin bad++; $display("FAIL lat_gen: got %0d want 0", bus.tb_ins); end
    @(negedge clk);
    total++; if (bus.tb_ins !== RD || bus.tb_ins_addr !== 4'd3) begin
      bad++; $display("FAIL first_op: got op=%0d addr=%0d want op=2 addr=3", bus.tb_ins, bus.tb_ins_addr); end
    bus.tb_ins_ack = 1'b1;
    @(negedge clk);
    total++; if (bus.tb_ins !== NOP || bus.tb_ins_addr !== 4'd3 || ins_cnt !== 16'd1 || rd_cnt !== 16'd1 || wr_cnt !== 16'd0) begin
      bad++; $display("FAIL first_release: got op=%0d addr=%0d ins=%0d rd=%0d wr=%0d want 0 3 1 1 0",
                      bus.tb_ins, bus.tb_ins_addr, ins_cnt, rd_cnt, wr_cnt); end
    bus.tb_ins_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (bus.tb_ins !== WR || bus.tb_ins_addr !== 4'd6) begin
      bad++; $display("FAIL second_op: got op=%0d addr=%0d want op=1 addr=6", bus.tb_ins, bus.tb_ins_addr); end
    bus.tb_ins_ack = 1'b1;
    @(negedge clk);
    bus.tb_ins_ack = 1'b0;
    total++; if (ins_cnt !== 16'd2 || wr_cnt !== 16'd1) begin
      bad++; $display("FAIL second_release: got ins=%0d wr=%0d want 2 1", ins_cnt, wr_cnt); end
    @(negedge clk);
    @(negedge clk);
    total++; if (bus.tb_ins !== NOP || ins_cnt !== 16'd2) begin
      bad++; $display("FAIL gap_cycle: got op=%0d ins=%0d want 0 2", bus.tb_ins, ins_cnt); end
    @(negedge clk);
    total++; if (bus.tb_ins !== NOP || ins_cnt !== 16'd3) begin
      bad++; $display("FAIL gap_end: got op=%0d ins=%0d want 0 3", bus.tb_ins, ins_cnt); end
    wait_issue("pre_rst");
    #1 rst = 1'b1;
    #1;
    total++; if (bus.tb_ins !== NOP || bus.tb_ins_addr !== 4'd0 || ins_cnt !== 16'd0) begin
      bad++; $display("FAIL async_rst: got op=%0d addr=%0d ins=%0d want 0 0 0", bus.tb_ins, bus.tb_ins_addr, ins_cnt); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    en = 1'b1;
    run_auto(12, 300);
  endtask

  task automatic test_timeout();
    bit stable;
    apply_reset();
    en = 1'b1;
    wait_issue("timeout");
    stable = 1'b1;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_early: got %0b want 0", err); end
    for (int k = 1; k <= 600; k++) begin
      if (k > 1) @(negedge clk);
      if (bus.tb_ins !== RD || bus.tb_ins_addr !== 4'd3) stable = 1'b0;
      if (k == 500) begin
        total++; if (err !== 1'b0) begin bad++; $display("FAIL err_500: got %0b want 0", err); end
      end
      if (k == 501) begin
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_501: got %0b want 1", err); end
      end
    end
    total++; if (!stable) begin bad++; $display("FAIL issue_stable: got changed want RD@3 held"); end
    bus.tb_ins_ack = 1'b1;
    @(negedge clk);
    total++; if (bus.tb_ins !== NOP || ins_cnt !== 16'd1 || err !== 1'b1) begin
      bad++; $display("FAIL late_ack: got op=%0d ins=%0d err=%0b want 0 1 1", bus.tb_ins, ins_cnt, err); end
    bus.tb_ins_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (bus.tb_ins !== WR || bus.tb_ins_addr !== 4'd6 || err !== 1'b1) begin
      bad++; $display("FAIL after_timeout: got op=%0d addr=%0d err=%0b want 1 6 1", bus.tb_ins, bus.tb_ins_addr, err); end
  endtask

  task automatic test_ack_hold();
    apply_reset();
    en = 1'b1;
    wait_issue("hold");
    bus.tb_ins_ack = 1'b1;
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      total++;
      if (bus.tb_ins !== NOP || ins_cnt !== 16'd1) begin
        bad++; $display("FAIL ack_hold_%0d: got op=%0d ins=%0d want 0 1", h, bus.tb_ins, ins_cnt);
      end
    end
    total++; if (rd_cnt !== 16'd1 || wr_cnt !== 16'd0) begin
      bad++; $display("FAIL ack_hold_cnt: got rd=%0d wr=%0d want 1 0", rd_cnt, wr_cnt); end
    bus.tb_ins_ack = 1'b0;
    @(negedge clk);
    total++; if (bus.tb_ins !== NOP) begin bad++; $display("FAIL ack_drop_gen: got %0d want 0", bus.tb_ins); end
    @(negedge clk);
    total++; if (bus.tb_ins !== WR) begin bad++; $display("FAIL ack_drop_next: got %0d want 1", bus.tb_ins); end
  endtask

  task automatic test_done();
    int iss, n, nonnop;
    logic [15:0] l;
    logic prev;
    bit quiet;
    apply_reset();
    l = 16'h0001;
    nonnop = 0;
    for (int k = 0; k < 4; k++) begin
      l = lfsr_step(l);
      if (l[15:14] != 2'b00) nonnop++;
    end
    en_s = 1'b1;
    iss = 0; n = 0; prev = 1'b0;
    while (!done_s && n < 400) begin
      @(negedge clk);
      if (bus_s.tb_ins != NOP && !prev) iss++;
      prev = (bus_s.tb_ins != NOP);
      bus_s.tb_ins_ack = prev;
      n++;
    end
    total++; if (done_s !== 1'b1) begin bad++; $display("FAIL done_rise: got %0b want 1", done_s); end
    total++; if (ins_cnt_s !== 16'd4) begin bad++; $display("FAIL done_ins_cnt: got %0d want 4", ins_cnt_s); end
    total++; if (int'(wr_cnt_s) + int'(rd_cnt_s) !== nonnop || iss !== nonnop) begin
      bad++; $display("FAIL done_wr_rd: got wr+rd=%0d issued=%0d want %0d", int'(wr_cnt_s) + int'(rd_cnt_s), iss, nonnop); end
    quiet = 1'b1;
    for (int k = 0; k < 20; k++) begin
      bus_s.tb_ins_ack = ~bus_s.tb_ins_ack;
      @(negedge clk);
      if (bus_s.tb_ins !== NOP || done_s !== 1'b1) quiet = 1'b0;
    end
    total++; if (!quiet || ins_cnt_s !== 16'd4) begin
      bad++; $display("FAIL done_sticky: got quiet=%0b ins=%0d want 1 4", quiet, ins_cnt_s); end
    en_s = 1'b0;
    bus_s.tb_ins_ack = 1'b0;
  endtask

  task automatic test_addr_sweep();
    apply_reset();
    seen = '0;
    max_addr = '0;
    en = 1'b1;
    run_auto(10000, 70000);
    total++; if (max_addr > 4'(ADDR_MAX)) begin bad++; $display("FAIL addr_max: got %0d want <=%0d", max_addr, ADDR_MAX); end
    total++; if (seen[9:0] !== 10'h3FF) begin bad++; $display("FAIL addr_cover: got %h want 3ff", seen[9:0]); end
  endtask

  // Drop en_i in ISSUE: op completes, generator parks, and the stream resumes unchanged
  task automatic test_en_drop();
    int n0, n, ins_exp;
    n0 = issues;
    n = 0;
    while (issues == n0 && n < 200) begin
      auto_step();
      n++;
    end
    ins_exp = int'(ins_cnt) + 1;
    en = 1'b0;
    n0 = issues;
    repeat (30) auto_step();
    total++; if (int'(ins_cnt) !== ins_exp || issues !== n0 || bus.tb_ins !== NOP) begin
      bad++; $display("FAIL en_drop_park: got ins=%0d new_issues=%0d op=%0d want %0d 0 0",
                      ins_cnt, issues - n0, bus.tb_ins, ins_exp); end
    first = 1'b1;
    en = 1'b1;
    run_auto(ins_exp + 4, 400);
  endtask

  initial begin
    issues = 0;
    seen = '0;
    max_addr = '0;
    test_reset();
    test_latency_first_ops();
    test_timeout();
    test_ack_hold();
    test_done();
    test_addr_sweep();
    test_en_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
